// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter with bounded burst lock in front of a single-port BRAM.
// Issues registered BRAM accesses and routes read data back via a tag pipeline.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int unsigned TAG_D = READ_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_e;

  own_e              state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic [TAG_D-1:0]  tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0]  tag_id_q, tag_id_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              burst_ok;

  // Grant decision: held lock first, then single requester, then round-robin tie break.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    burst_ok = (burst_cnt_q < 8'(MAX_BURST));
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (state_q == OWN0 && req0 && lock0 && (burst_ok || !req1)) begin
      gnt0 = 1'b1;
    end else if (state_q == OWN1 && req1 && lock1 && (burst_ok || !req0)) begin
      gnt1 = 1'b1;
    end else if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = last_q;
      gnt1 = !last_q;
    end
  end

  // Next-state: owner/burst tracking, BRAM port load, read tag pipeline and return.
  always_comb begin
    state_d     = IDLE;
    last_d      = last_q;
    burst_cnt_d = 8'd0;
    ena_d       = 1'b0;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    if (gnt0 || gnt1) begin
      state_d = gnt1 ? OWN1 : OWN0;
      last_d  = gnt1;
      if (state_q == state_d) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end else begin
        burst_cnt_d = 8'd1;
      end
      ena_d   = 1'b1;
      wea_d   = gnt1 ? we1 : we0;
      addra_d = gnt1 ? addr1 : addr0;
      dina_d  = gnt1 ? wdata1 : wdata0;
    end
    tag_vld_d = {tag_vld_q[TAG_D-2:0], (gnt0 || gnt1) && !wea_d};
    tag_id_d  = {tag_id_q[TAG_D-2:0], gnt1};
    rvalid0_d = tag_vld_q[TAG_D-1] && !tag_id_q[TAG_D-1];
    rvalid1_d = tag_vld_q[TAG_D-1] && tag_id_q[TAG_D-1];
    rdata0_d  = rvalid0_d ? douta : rdata0_q;
    rdata1_d  = rvalid1_d ? douta : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= 8'd0;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ena     = ena_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
